// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory arbiter: owner encodings, default
// parameter values and the lock-counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DBG  = 2'b10
    } owner_t;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int MAX_LOCK_DEF = 8;

    // Counter only has to reach MAX_LOCK-1.
    function automatic int lock_cnt_w(input int max_lock);
        return (max_lock > 2) ? $clog2(max_lock) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_lock_counter.sv
// arb_lock_counter
// Counts consecutive locked grant cycles for the current bus owner.
// Saturates at MAX_LOCK-1 and flags that value as expired.
// Ports:
//   clk, reset (async, active-low)
//   clear    - return to zero (wins over inc)
//   inc      - advance by one unless already expired
//   cnt      - current count
//   expired  - cnt == MAX_LOCK-1
module arb_lock_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF,
    parameter int CNT_W    = lock_cnt_w(MAX_LOCK)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             expired
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK - 1);

    assign expired = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port (CPU datapath / debug loader) arbiter for memory_unit with
// bounded bus locking. Grants are registered; the memory bus is a
// combinational mux of the current owner's request.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking
// (default build: fixed priority, CPU wins ties).
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/lock/we/addr/wdata, cpu_gnt  - datapath port
//   dbg_req/lock/we/addr/wdata, dbg_gnt  - debug/loader port
//   mem_we, mem_abus, mem_wbus           - memory_unit bus
//   owner                                - current owner encoding
//
// state    | meaning
// ---------+--------------------------------------------
// OWN_NONE | bus idle, outputs forced to zero
// OWN_CPU  | datapath owns the bus
// OWN_DBG  | debug/loader owns the bus
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_lock,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    input  logic              dbg_req,
    input  logic              dbg_lock,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_abus,
    output logic [DATA_W-1:0] mem_wbus,
    output logic [1:0]        owner
);

    localparam int CNT_W = lock_cnt_w(MAX_LOCK);

    owner_t             owner_q, owner_d, oth_id, tie_winner;
    logic               own_req, own_lock, oth_req, own_valid;
    logic               lock_inc, lock_hold, lock_exp;
    logic [CNT_W-1:0]   lock_cnt;

`ifdef MEM_ARB_RR_EN
    owner_t             last_served;
    assign tie_winner = (last_served == OWN_CPU) ? OWN_DBG : OWN_CPU;
`else
    assign tie_winner = OWN_CPU;
`endif

    assign owner = owner_q;

    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        oth_req   = 1'b0;
        oth_id    = OWN_NONE;
        own_valid = 1'b0;
        case (owner_q)
            OWN_CPU: begin
                own_valid = 1'b1;
                own_req   = cpu_req;
                own_lock  = cpu_lock;
                oth_req   = dbg_req;
                oth_id    = OWN_DBG;
            end
            OWN_DBG: begin
                own_valid = 1'b1;
                own_req   = dbg_req;
                own_lock  = dbg_lock;
                oth_req   = cpu_req;
                oth_id    = OWN_CPU;
            end
            default: ;
        endcase
    end

    // Next owner. lock_hold keeps a saturated count while the owner is
    // re-granted with lock still high; every other path clears it.
    always_comb begin
        owner_d   = OWN_NONE;
        lock_inc  = 1'b0;
        lock_hold = 1'b0;
        if (!own_valid) begin
            if (cpu_req && dbg_req) owner_d = tie_winner;
            else if (cpu_req)       owner_d = OWN_CPU;
            else if (dbg_req)       owner_d = OWN_DBG;
        end else if (own_req && own_lock && !lock_exp) begin
            owner_d  = owner_q;
            lock_inc = 1'b1;
        end else if (oth_req) begin
            owner_d = oth_id;
        end else if (own_req) begin
            owner_d   = owner_q;
            lock_hold = own_lock;
        end
    end

    arb_lock_counter #(
        .MAX_LOCK (MAX_LOCK),
        .CNT_W    (CNT_W)
    ) u_lock_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (!lock_inc && !lock_hold),
        .inc     (lock_inc),
        .cnt     (lock_cnt),
        .expired (lock_exp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= OWN_NONE;
            cpu_gnt     <= 1'b0;
            dbg_gnt     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_served <= OWN_DBG;
`endif
        end else begin
            owner_q <= owner_d;
            cpu_gnt <= (owner_d == OWN_CPU);
            dbg_gnt <= (owner_d == OWN_DBG);
`ifdef MEM_ARB_RR_EN
            if (owner_d != OWN_NONE) last_served <= owner_d;
`endif
        end
    end

    // A requester dropping req while granted cancels its write.
    always_comb begin
        mem_we   = 1'b0;
        mem_abus = '0;
        mem_wbus = '0;
        case (owner_q)
            OWN_CPU: begin
                mem_we   = cpu_we && cpu_req;
                mem_abus = cpu_addr;
                mem_wbus = cpu_wdata;
            end
            OWN_DBG: begin
                mem_we   = dbg_we && dbg_req;
                mem_abus = dbg_addr;
                mem_wbus = dbg_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with hand-computed expectations.
// Build with MEM_ARB_RR_EN defined to cover the round-robin tie policy.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int MAX_LOCK = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_lock, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              dbg_req, dbg_lock, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_abus;
    logic [DATA_W-1:0] mem_wbus;
    logic [1:0]        owner;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_lock  (cpu_lock),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .dbg_req   (dbg_req),
        .dbg_lock  (dbg_lock),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .mem_we    (mem_we),
        .mem_abus  (mem_abus),
        .mem_wbus  (mem_wbus),
        .owner     (owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_lock = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_lock = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    int run_len;

    initial begin
        reset = 1'b1;
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        check("rst_owner", 32'(owner), 32'(OWN_NONE));
        check("rst_gnts", {cpu_gnt, dbg_gnt}, 0);
        check("rst_mem", {mem_we, mem_abus, mem_wbus}, 0);
        tick();
        reset = 1'b1;
        check("rst_lock_cnt", 32'(dut.lock_cnt), 0);

        // CPU write: grant one cycle after request
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
        #1;
        check("wr_no_gnt_yet", 32'(cpu_gnt), 0);
        tick();
        check("wr_cpu_gnt", 32'(cpu_gnt), 1);
        check("wr_dbg_gnt", 32'(dbg_gnt), 0);
        check("wr_mem_we", 32'(mem_we), 1);
        check("wr_mem_abus", 32'(mem_abus), 32'h0010);
        check("wr_mem_wbus", 32'(mem_wbus), 32'hBEEF);
        check("wr_owner", 32'(owner), 32'(OWN_CPU));

        // Tie from NONE, then CPU drops
        do_reset();
        cpu_req = 1; dbg_req = 1;
        tick();
        check("tie1_cpu_gnt", 32'(cpu_gnt), 1);
        check("tie1_dbg_gnt", 32'(dbg_gnt), 0);
        cpu_req = 0;
        tick();
        check("tie1_then_dbg", 32'(dbg_gnt), 1);
        check("tie1_then_cpu", 32'(cpu_gnt), 0);

        // Repeated ties from idle
        do_reset();
        cpu_req = 1; dbg_req = 1;
        tick();
        check("ties_a", 32'(owner), 32'(OWN_CPU));
        cpu_req = 0; dbg_req = 0;
        tick();
        check("ties_idle", 32'(owner), 32'(OWN_NONE));
        cpu_req = 1; dbg_req = 1;
        tick();
`ifdef MEM_ARB_RR_EN
        check("ties_b", 32'(owner), 32'(OWN_DBG));
`else
        check("ties_b", 32'(owner), 32'(OWN_CPU));
`endif
        cpu_req = 0; dbg_req = 0;
        tick();
        cpu_req = 1; dbg_req = 1;
        tick();
        check("ties_c", 32'(owner), 32'(OWN_CPU));

        // DBG lock with CPU waiting: exactly MAX_LOCK cycles then CPU
        do_reset();
        dbg_req = 1; dbg_lock = 1;
        tick();
        check("lk_first_gnt", 32'(dbg_gnt), 1);
        cpu_req = 1;
        run_len = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (dbg_gnt) run_len++;
            else break;
        end
        check("lk_run_len", run_len, MAX_LOCK);
        check("lk_cpu_next", 32'(cpu_gnt), 1);
        check("lk_owner_cpu", 32'(owner), 32'(OWN_CPU));

        // DBG locked alone for 20 cycles: saturates
        do_reset();
        dbg_req = 1; dbg_lock = 1;
        tick();
        run_len = 0;
        for (int i = 0; i < 20; i++) begin
            if (dbg_gnt) run_len++;
            tick();
        end
        check("sat_gnt_cycles", run_len, 20);
        check("sat_still_gnt", 32'(dbg_gnt), 1);
        check("sat_lock_cnt", 32'(dut.lock_cnt), MAX_LOCK - 1);

        // CPU drops req in its grant cycle: write cancelled
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h1234; cpu_wdata = 16'h5678;
        tick();
        check("drop_gnt", 32'(cpu_gnt), 1);
        cpu_req = 0;
        #1;
        check("drop_mem_we", 32'(mem_we), 0);
        tick();
        check("drop_owner", 32'(owner), 32'(OWN_NONE));
        check("drop_gnt_off", 32'(cpu_gnt), 0);

        // Async reset mid-lock with a write in flight
        do_reset();
        cpu_req = 1; cpu_lock = 1; cpu_we = 1; cpu_addr = 16'h00AA; cpu_wdata = 16'h5555;
        tick();
        tick();
        tick();
        check("mid_pre_we", 32'(mem_we), 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_mem_we", 32'(mem_we), 0);
        check("mid_gnts", {cpu_gnt, dbg_gnt}, 0);
        check("mid_owner", 32'(owner), 32'(OWN_NONE));
        check("mid_lock_cnt", 32'(dut.lock_cnt), 0);
        tick();
        reset = 1'b1;
        tick();
        check("mid_resume", 32'(cpu_gnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
